// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration bundle between the requesting masters and the arbiter that
// shares the AHB-to-APB bridge. The arbiter connects through the slave
// modport; the master side (request/lock/transfer/ready drivers) uses master.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_W    = 2
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MASTER_W-1:0]    hmaster;
    logic                   hmastlock;

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter in front of the AHB-to-APB bridge.
// Grants one master the address bus (hgrant), hands the address phase over
// one ready cycle later (hmaster), caps each tenure at MAX_BEATS counted beats
// and parks on DEFAULT_MASTER when nobody requests. All state advances only
// on edges where the bridge reports hready=1.
// Optional feature macro: ARB_LOCK_EN adds the LOCKED state and hmastlock.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_W       = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_bus_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_LOCKED} state_t;

    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0]    DEFAULT_IDX   = MASTER_W'(DEFAULT_MASTER);
    localparam logic [4:0]             CAP           = 5'(MAX_BEATS);

    state_t                 state_reg;
    logic [NUM_MASTERS-1:0] hgrant_reg;
    logic [MASTER_W-1:0]    owner_reg;
    logic [MASTER_W-1:0]    hmaster_reg;
    logic                   hmastlock_reg;
    logic [4:0]             cnt_reg;

    logic                   win_found;
    logic [MASTER_W-1:0]    win_idx;
    logic [NUM_MASTERS-1:0] win_grant;
    logic                   req_owner;
    logic                   beat;
    logic                   arb_ok;
    logic                   lock_enter;
    logic                   lock_exit;
    logic                   lock_keep;

    assign req_owner = bus.hbusreq[owner_reg];
    // A beat is an active transfer (NONSEQ/SEQ) issued by the address-phase owner.
    assign beat      = bus.htrans[1] && (hmaster_reg == owner_reg);

`ifdef ARB_LOCK_EN
    assign lock_enter = (state_reg == ST_OWN) && bus.hlock[owner_reg] && req_owner;
    assign lock_exit  = (state_reg == ST_LOCKED) && !bus.hlock[owner_reg];
    assign lock_keep  = (state_reg == ST_LOCKED) && bus.hlock[owner_reg];
`else
    logic unused_hlock;
    assign unused_hlock = ^bus.hlock;
    assign lock_enter   = 1'b0;
    assign lock_exit    = 1'b0;
    assign lock_keep    = 1'b0;
`endif

    // Re-arbitrate only between bursts (never mid SEQ/BUSY) and only when the
    // owner let go, used up its beat cap, or the bus is parked.
    assign arb_ok = (state_reg != ST_LOCKED) && !bus.htrans[0] &&
                    (!req_owner || (cnt_reg >= CAP) || (state_reg == ST_PARK));

    // Rotating priority search: owner+1 first, owner itself last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = DEFAULT_IDX;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            int idx;
            idx = (int'(owner_reg) + i) % NUM_MASTERS;
            if (!win_found && bus.hbusreq[idx]) begin
                win_found = 1'b1;
                win_idx   = MASTER_W'(idx);
            end
        end
    end

    // One-hot form of the winner (the default master when nobody requests).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_win_onehot
            assign win_grant[gi] = (win_idx == MASTER_W'(gi));
        end
    endgenerate

    // Grant, ownership, beat counting and address-phase handover; frozen while
    // the bridge inserts wait states.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg     <= ST_PARK;
            hgrant_reg    <= DEFAULT_GRANT;
            owner_reg     <= DEFAULT_IDX;
            hmaster_reg   <= DEFAULT_IDX;
            hmastlock_reg <= 1'b0;
            cnt_reg       <= 5'd0;
        end else if (bus.hready) begin
            hmaster_reg   <= owner_reg;
            hmastlock_reg <= lock_enter || lock_keep;
            if (beat && (cnt_reg < CAP)) begin
                cnt_reg <= cnt_reg + 5'd1;
            end
            if (lock_enter) begin
                state_reg <= ST_LOCKED;
            end else if (lock_exit) begin
                // Leave the lock first; arbitration resumes on the next ready edge.
                state_reg <= ST_OWN;
            end else if (arb_ok) begin
                cnt_reg    <= 5'd0;
                hgrant_reg <= win_grant;
                owner_reg  <= win_idx;
                state_reg  <= win_found ? ST_OWN : ST_PARK;
            end
        end
    end

    assign bus.hgrant    = hgrant_reg;
    assign bus.hmaster   = hmaster_reg;
    assign bus.hmastlock = hmastlock_reg;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed-vector bench for ahb_bus_arbiter with MAX_BEATS=4. A driver applies
// one vector per cycle and queues the expected outputs after that edge; an
// independent monitor pops and compares one entry after every rising edge.
module tb_ahb_bus_arbiter;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset = 1'b1;

    ahb_bus_arbiter_if #(.NUM_MASTERS(4), .MASTER_W(2)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS(4), .MASTER_W(2), .DEFAULT_MASTER(0), .MAX_BEATS(4)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    logic [6:0] exp_q[$];
    string      name_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic step(input logic r, input logic rdy, input logic [3:0] req,
                        input logic [3:0] lk, input logic [1:0] tr,
                        input logic [3:0] eg, input logic [1:0] em,
                        input logic el, input string nm);
        @(negedge hclk);
        hreset         = r;
        bus.hready     = rdy;
        bus.hbusreq    = req;
        bus.hlock      = lk;
        bus.htrans     = tr;
        exp_q.push_back({eg, em, el});
        name_q.push_back(nm);
    endtask

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    // Monitor: one expectation per rising edge, compared just after it.
    initial begin
        forever begin
            @(posedge hclk);
            #1;
            if (exp_q.size() > 0) begin
                logic [6:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ({bus.hgrant, bus.hmaster, bus.hmastlock} !== e) begin
                    errors++;
                    $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmastlock=%b",
                             nm, bus.hgrant, bus.hmaster, bus.hmastlock, e[6:3], e[2:1], e[0]);
                end else begin
                    $display("ok   %s: hgrant=%b hmaster=%0d hmastlock=%b",
                             nm, bus.hgrant, bus.hmaster, bus.hmastlock);
                end
            end
        end
    end

    initial begin
        bus.hready  = 1'b1;
        bus.hbusreq = 4'b0000;
        bus.hlock   = 4'b0000;
        bus.htrans  = IDLE;

        // Reset and parking on master 0 with no requests.
        step(1, 1, 4'h0, 4'h0, IDLE, 4'b0001, 0, 0, "reset");
        for (int i = 0; i < 10; i++)
            step(0, 1, 4'h0, 4'h0, IDLE, 4'b0001, 0, 0, "park_idle");

        // Single request from master 1: grant at edge 1, hmaster at edge 2.
        step(0, 1, 4'b0010, 4'h0, IDLE, 4'b0010, 0, 0, "req1_grant");
        step(0, 1, 4'b0010, 4'h0, IDLE, 4'b0010, 1, 0, "req1_hmaster");
        step(0, 1, 4'b0000, 4'h0, IDLE, 4'b0001, 1, 0, "req1_release");
        step(0, 1, 4'b0000, 4'h0, IDLE, 4'b0001, 0, 0, "park_again");

        // All request: 4-beat tenures rotating 1->2->3->0->1.
        for (int t = 0; t < 5; t++) begin
            int g;
            int p;
            g = (t + 1) % 4;
            p = t % 4;
            step(0, 1, 4'hF, 4'h0, (t == 0) ? IDLE : NONSEQ, oh(g), 2'(p), 0, "rot_arb");
            step(0, 1, 4'hF, 4'h0, IDLE,   oh(g), 2'(g), 0, "rot_handover");
            step(0, 1, 4'hF, 4'h0, NONSEQ, oh(g), 2'(g), 0, "rot_beat1");
            step(0, 1, 4'hF, 4'h0, SEQ,    oh(g), 2'(g), 0, "rot_beat2");
            step(0, 1, 4'hF, 4'h0, SEQ,    oh(g), 2'(g), 0, "rot_beat3");
            step(0, 1, 4'hF, 4'h0, SEQ,    oh(g), 2'(g), 0, "rot_beat4");
        end

        // Master 2 mid-burst, bridge stalls 3 cycles while requests change.
        step(0, 1, 4'hF, 4'h0, NONSEQ, 4'b0100, 1, 0, "stall_arb");
        step(0, 1, 4'hF, 4'h0, IDLE,   4'b0100, 2, 0, "stall_handover");
        step(0, 1, 4'hF, 4'h0, NONSEQ, 4'b0100, 2, 0, "stall_beat1");
        step(0, 1, 4'hF, 4'h0, SEQ,    4'b0100, 2, 0, "stall_beat2");
        step(0, 0, 4'b0000, 4'h0, IDLE, 4'b0100, 2, 0, "stall_wait1");
        step(0, 0, 4'b1000, 4'h0, IDLE, 4'b0100, 2, 0, "stall_wait2");
        step(0, 0, 4'b0001, 4'h0, IDLE, 4'b0100, 2, 0, "stall_wait3");
        step(0, 1, 4'hF, 4'h0, SEQ,    4'b0100, 2, 0, "stall_beat3");
        step(0, 1, 4'hF, 4'h0, SEQ,    4'b0100, 2, 0, "stall_beat4");
        step(0, 1, 4'hF, 4'h0, SEQ,    4'b0100, 2, 0, "cap_in_burst1");
        step(0, 1, 4'hF, 4'h0, SEQ,    4'b0100, 2, 0, "cap_in_burst2");
        step(0, 1, 4'hF, 4'h0, IDLE,   4'b1000, 2, 0, "cap_burst_end");

        // Owner 3 drops its request inside a burst: grant held until IDLE.
        step(0, 1, 4'hF,    4'h0, IDLE,   4'b1000, 3, 0, "drop_handover");
        step(0, 1, 4'hF,    4'h0, NONSEQ, 4'b1000, 3, 0, "drop_beat1");
        step(0, 1, 4'b0111, 4'h0, SEQ,    4'b1000, 3, 0, "drop_in_seq");
        step(0, 1, 4'b0111, 4'h0, BUSY,   4'b1000, 3, 0, "drop_in_busy");
        step(0, 1, 4'b0111, 4'h0, IDLE,   4'b0001, 3, 0, "drop_release");
        step(0, 1, 4'b0100, 4'h0, IDLE,   4'b0100, 0, 0, "to_master2");
        step(0, 1, 4'b0100, 4'h0, IDLE,   4'b0100, 2, 0, "master2_hmaster");

        // Reset mid-tenure wins even with hready low.
        step(1, 0, 4'b0100, 4'h0, SEQ,  4'b0001, 0, 0, "reset_mid");
        step(0, 1, 4'b0000, 4'h0, IDLE, 4'b0001, 0, 0, "reset_mid_park");

`ifdef ARB_LOCK_EN
        // Master 1 locks past the beat cap; release re-arbitrates one ready edge later.
        step(0, 1, 4'hF, 4'b0010, IDLE, 4'b0010, 0, 0, "lock_grant");
        step(0, 1, 4'hF, 4'b0010, IDLE, 4'b0010, 1, 1, "lock_enter");
        for (int i = 0; i < 40; i++)
            step(0, 1, 4'hF, 4'b0010, (i % 4 == 0) ? NONSEQ : SEQ, 4'b0010, 1, 1, "lock_hold");
        step(0, 1, 4'hF, 4'b0000, IDLE, 4'b0010, 1, 0, "lock_exit");
        step(0, 0, 4'hF, 4'b0000, IDLE, 4'b0010, 1, 0, "lock_exit_wait");
        step(0, 1, 4'hF, 4'b0000, IDLE, 4'b0100, 1, 0, "lock_rearb");
        step(0, 1, 4'hF, 4'b0000, IDLE, 4'b0100, 2, 0, "lock_rearb_hmaster");
        step(0, 1, 4'hF, 4'b0100, IDLE,   4'b0100, 2, 1, "relock_enter");
        step(0, 1, 4'hF, 4'b0100, NONSEQ, 4'b0100, 2, 1, "relock_beat");
        step(1, 1, 4'hF, 4'b0100, SEQ,    4'b0001, 0, 0, "reset_in_lock");
        step(0, 1, 4'h0, 4'b0000, IDLE,   4'b0001, 0, 0, "reset_in_lock_park");
`else
        // Without lock support hlock is ignored: the beat cap still rotates.
        step(0, 1, 4'hF, 4'hF, IDLE,   4'b0010, 0, 0, "nolock_grant");
        step(0, 1, 4'hF, 4'hF, IDLE,   4'b0010, 1, 0, "nolock_handover");
        step(0, 1, 4'hF, 4'hF, NONSEQ, 4'b0010, 1, 0, "nolock_beat1");
        step(0, 1, 4'hF, 4'hF, SEQ,    4'b0010, 1, 0, "nolock_beat2");
        step(0, 1, 4'hF, 4'hF, SEQ,    4'b0010, 1, 0, "nolock_beat3");
        step(0, 1, 4'hF, 4'hF, SEQ,    4'b0010, 1, 0, "nolock_beat4");
        step(0, 1, 4'hF, 4'hF, NONSEQ, 4'b0100, 1, 0, "nolock_rearb");
        step(0, 1, 4'hF, 4'hF, IDLE,   4'b0100, 2, 0, "nolock_hmaster");
`endif

        repeat (2) @(posedge hclk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

- Shares the AHB-to-APB bridge between up to four AHB masters: grants one master the address bus, tracks data-phase ownership and drives the master-select index used by the address/write-data muxes in front of the bridge.
- Arbitration is round-robin with a per-tenure beat cap, optional locked-transfer support, and parking on a default master when no one requests.
- Decisions advance only when the bridge signals ready (hready high), so bridge wait states freeze all arbiter state.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters (2..4)
- MASTER_W, 2, width of hmaster
- DEFAULT_MASTER, 0, park master when no requests
- MAX_BEATS, 16, transfers a master may own before forced re-arbitration (1..31)

Ports:
- hclk  in  1  clock; all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- hbusreq  in  NUM_MASTERS  per-master bus request
- hlock  in  NUM_MASTERS  per-master locked-transfer request
- htrans  in  2  transfer type of the currently muxed master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hready  in  1  bridge ready (bridge hr_readyout)
- hgrant  out  NUM_MASTERS  one-hot grant, registered
- hmaster  out  MASTER_W  index of address-phase owner, registered
- hmastlock  out  1  current transfer is locked, registered

## Operation
- Owner: index encoded by hgrant.
- States:
  - PARK: DEFAULT_MASTER granted, no requests pending.
  - OWN: a requester granted.
  - LOCKED: owner holds the bus unconditionally.
- Beat counter cnt, 5 bits:
  - Increments, saturating at MAX_BEATS, on each edge with hready=1, htrans in {NONSEQ, SEQ} and hmaster == owner.
  - Cleared whenever hgrant changes.
- arb_ok, evaluated at edges with hready=1: state != LOCKED AND htrans not in {BUSY, SEQ} AND (hbusreq[owner]=0 OR cnt >= MAX_BEATS OR state == PARK).
- Winner when arb_ok:
  - First set bit of hbusreq scanning owner+1, owner+2, … wrapping modulo NUM_MASTERS, ending with owner itself.
  - No request: DEFAULT_MASTER, state PARK.
  - Winner == owner: grant kept, cnt cleared.
  - Otherwise state OWN.
- Lock entry (OWN -> LOCKED): hready=1 edge where hlock[owner]=1 and hbusreq[owner]=1. Takes priority over arb_ok.
- Lock exit (LOCKED -> OWN): edge with hready=1 and hlock[owner]=0. Re-arbitration is evaluated no earlier than the following hready=1 edge.
- hmaster / hmastlock: on each hready=1 edge, hmaster <= owner and hmastlock <= hlock[owner] & (state == LOCKED or entering LOCKED). This is the address-phase handover one hready cycle after the grant.
- Requests and locks of non-owners are ignored except for winner selection.

## Timing
- Reset values: hgrant = 1<<DEFAULT_MASTER, hmaster = DEFAULT_MASTER, hmastlock = 0, cnt = 0, state = PARK.
- Reset mid-tenure takes effect on the next edge regardless of hready.
- hready=0: every register holds its value; hbusreq, hlock and htrans are not sampled.
- Grant latency:
  - From PARK, a request seen at edge N gives hgrant at edge N (visible after N).
  - hmaster follows at the next hready=1 edge, so the minimum request-to-hmaster latency is 2 cycles.
- Simultaneous requests: the rotating pointer guarantees each requester a grant within NUM_MASTERS tenures.
- The owner dropping hbusreq during SEQ/BUSY does not release the grant until htrans is IDLE or NONSEQ.
- cnt saturation while owner is in a SEQ burst: grant held until the burst ends (htrans IDLE/NONSEQ), then re-arbitrated.

## Configuration
- ARB_LOCK_EN defined: LOCKED state, lock entry/exit and hmastlock are implemented as above.
- ARB_LOCK_EN undefined:
  - hlock is ignored and the LOCKED state does not exist.
  - hmastlock is tied to 0.
  - The beat cap always applies.

## Test plan
- Reset, no requests -> hgrant=0001, hmaster=0, hmastlock=0, held for 10 cycles.
- hbusreq=0010, htrans IDLE, hready=1 -> hgrant=0010 after edge 1, hmaster=1 after edge 2.
- hbusreq=1111 held, owner issues NONSEQ then SEQ each cycle, MAX_BEATS=4 -> grant rotates 0->1->2->3->0, each tenure 4 counted beats.
- Owner 2 in SEQ burst, hready low 3 cycles while hbusreq changes -> hgrant, hmaster and cnt unchanged until hready returns.
- ARB_LOCK_EN, owner 1 asserts hlock with hbusreq=1111 for 40 beats -> hgrant stays 0010 past MAX_BEATS, hmastlock=1. hlock drops -> hgrant=0100 at the second hready=1 edge after the drop.
- hreset asserted during a locked 2-beat-old tenure -> next edge: hgrant=0001, hmaster=0, hmastlock=0, cnt=0.
